seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 153 +++++++++++++++
 tb/tb_seq_multiplier.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: WIDTH x WIDTH shift-add multiplier using a single WIDTH+1-bit adder, one
// partial product per clock, with a start/done handshake. Define SEQ_MUL_SIGNED_EN for signed mode.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0]   a_load_s;
    logic [WIDTH-1:0]   b_load_s;
    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] result_s;

`ifdef SEQ_MUL_SIGNED_EN
    logic               neg_r;
    logic               neg_load_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction
`endif

    // Operand capture values: magnitudes and result sign in signed mode, raw operands otherwise.
    always_comb begin
        a_load_s = a;
        b_load_s = b;
`ifdef SEQ_MUL_SIGNED_EN
        neg_load_s = 1'b0;
        if (signed_mode) begin
            a_load_s   = a[WIDTH-1] ? neg_w(a) : a;
            b_load_s   = b[WIDTH-1] ? neg_w(b) : b;
            neg_load_s = a[WIDTH-1] ^ b[WIDTH-1];
        end else begin
            a_load_s   = a;
            b_load_s   = b;
            neg_load_s = 1'b0;
        end
`endif
    end

    // One shift-add step; the carry out of the upper half re-enters at the MSB on the shift.
    always_comb begin
        addend_s = {WIDTH{1'b0}};
        if (acc_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
        result_s   = acc_next_s;
`ifdef SEQ_MUL_SIGNED_EN
        if (neg_r) begin
            result_s = neg_2w(acc_next_s);
        end else begin
            result_s = acc_next_s;
        end
`endif
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mcand_r   <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
`ifdef SEQ_MUL_SIGNED_EN
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r <= a_load_s;
                        acc_r   <= {{WIDTH{1'b0}}, b_load_s};
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`ifdef SEQ_MUL_SIGNED_EN
                        neg_r   <= neg_load_s;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_ITER) begin
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= result_s;
                        state_r   <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a WIDTH=4 instance (directed + random) and a WIDTH=8 instance.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;
`ifdef SEQ_MUL_SIGNED_EN
    logic        sm4;
`endif

    logic        rst8_n;
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] product8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference-model state: last accepted edge index, expected results, held product.
    logic        have4 = 1'b0;
    int          acc4  = 0;
    logic [7:0]  q4[$];
    logic [7:0]  held4 = 8'd0;
    logic        bexp4, dexp4;

    logic        have8 = 1'b0;
    int          acc8  = 0;
    logic [15:0] q8[$];
    logic [15:0] held8 = 16'd0;
    logic        bexp8, dexp8;
    logic        drv8_done = 1'b0;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
`ifdef SEQ_MUL_SIGNED_EN
        .signed_mode(sm4),
`endif
        .busy(busy4), .done(done4), .product(product4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8),
`ifdef SEQ_MUL_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .busy(busy8), .done(done8), .product(product8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic sm);
        int sx, sy, p;
        sx = int'(x);
        sy = int'(y);
        if (sm && x >= 4'd8) sx = int'(x) - 16;
        if (sm && y >= 4'd8) sy = int'(y) - 16;
        p = sx * sy;
        return p[7:0];
    endfunction

    // Issue a start at a negedge; the model decides whether the DUT can accept it.
    task automatic drive4(input logic [3:0] x, input logic [3:0] y, input logic sm);
        int e;
        logic smx;
        smx = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
        smx = sm;
        sm4 = sm;
`endif
        a4 = x; b4 = y; start4 = 1'b1;
        e = cyc + 1;
        if (!have4 || e >= acc4 + 5) begin
            q4.push_back(ref4(x, y, smx));
            have4 = 1'b1;
            acc4  = e;
        end
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
`ifdef SEQ_MUL_SIGNED_EN
        sm4 = 1'($urandom);
`endif
    endtask

    task automatic wait_free4();
        while (have4 && (cyc + 1 < acc4 + 5)) @(negedge clk);
    endtask

    task automatic drive8(input logic [7:0] x, input logic [7:0] y);
        a8 = x; b8 = y; start8 = 1'b1;
        if (!have8 || cyc + 1 >= acc8 + 9) begin
            q8.push_back(16'(int'(x) * int'(y)));
            have8 = 1'b1;
            acc8  = cyc + 1;
        end
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    // WIDTH=4 monitor: per-cycle busy/done/held-product checks, product popped on done.
    always begin
        @(posedge clk);
        #1;
        bexp4 = have4 && (cyc >= acc4) && (cyc < acc4 + 4);
        dexp4 = have4 && (cyc == acc4 + 4);
        chk("busy4", 16'(busy4), 16'(bexp4));
        chk("done4", 16'(done4), 16'(dexp4));
        if (done4) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL done4_spurious: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                held4 = q4.pop_front();
            end
        end
        chk("product4", 16'(product4), 16'(held4));
    end

    // WIDTH=8 monitor.
    always begin
        @(posedge clk);
        #1;
        bexp8 = have8 && (cyc >= acc8) && (cyc < acc8 + 8);
        dexp8 = have8 && (cyc == acc8 + 8);
        chk("busy8", 16'(busy8), 16'(bexp8));
        chk("done8", 16'(done8), 16'(dexp8));
        if (done8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL done8_spurious: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                held8 = q8.pop_front();
            end
        end
        chk("product8", product8, held8);
    end

    // WIDTH=8 stimulus: full-scale operands then random back-to-back and spaced requests.
    initial begin
        rst8_n = 1'b0; start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        repeat (3) @(negedge clk);
        rst8_n = 1'b1;
        @(negedge clk);
        drive8(8'd255, 8'd255);
        for (int i = 0; i < 12; i++) begin
            while (have8 && (cyc + 1 < acc8 + 9)) @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive8(8'($urandom), 8'($urandom));
        end
        while (have8 && (cyc + 1 < acc8 + 9)) @(negedge clk);
        repeat (2) @(negedge clk);
        drv8_done = 1'b1;
    end

    // WIDTH=4 stimulus: directed cases, mid-run reset, random traffic, optional signed cases.
    initial begin
        logic [3:0] x, y;
        logic       sm;
        rst_n = 1'b0; start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
`ifdef SEQ_MUL_SIGNED_EN
        sm4 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_busy", 16'(busy4), 16'd0);
        chk("reset_done", 16'(done4), 16'd0);
        chk("reset_product", 16'(product4), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        drive4(4'd15, 4'd15, 1'b0);
        wait_free4();
        repeat (3) @(negedge clk);

        drive4(4'd0, 4'd9, 1'b0); wait_free4(); @(negedge clk);
        drive4(4'd9, 4'd0, 1'b0); wait_free4(); @(negedge clk);
        drive4(4'd1, 4'd1, 1'b0); wait_free4(); @(negedge clk);

        // Start during RUN is ignored; then a start held in DONE is accepted.
        drive4(4'd6, 4'd7, 1'b0);
        @(negedge clk);
        drive4(4'd2, 4'd2, 1'b0);
        wait_free4();
        drive4(4'd2, 4'd2, 1'b0);
        wait_free4();
        repeat (2) @(negedge clk);

        drive4(4'd13, 4'd11, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        have4 = 1'b0;
        q4.delete();
        held4 = 8'd0;
        #1;
        chk("midrst_busy", 16'(busy4), 16'd0);
        chk("midrst_done", 16'(done4), 16'd0);
        chk("midrst_product", 16'(product4), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        drive4(4'd3, 4'd5, 1'b0);
        wait_free4();
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            x  = 4'($urandom);
            y  = 4'($urandom);
            sm = 1'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            drive4(x, y, sm);
        end
        wait_free4();
        @(negedge clk);

`ifdef SEQ_MUL_SIGNED_EN
        drive4(4'd8, 4'd8, 1'b1);   wait_free4(); @(negedge clk);
        drive4(4'd13, 4'd5, 1'b1);  wait_free4(); @(negedge clk);
        drive4(4'd13, 4'd5, 1'b0);  wait_free4(); @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("queue4_drained", 16'(q4.size()), 16'd0);

        for (int i = 0; i < 2000 && !drv8_done; i++) @(negedge clk);
        if (!drv8_done) begin
            total++; bad++;
            $display("FAIL w8_timeout: got unfinished expected finished");
        end
        chk("queue8_drained", 16'(q8.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
